// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice.
// Holds the default geometry used by regfile_sb and regfile_scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_WID_DEF = 32;
    localparam int unsigned ADDR_WID_DEF = 5;

    // Register 0 is hardwired: never written, never busy.
    function automatic logic is_real_reg(input logic [31:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one busy flag per register plus a running count.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   set_v / set_addr    - mark set_addr busy (issue)
//   clr_v / clr_addr    - clear busy on clr_addr (committed write)
//   busy                - registered busy vector, bit 0 always 0
//   cnt                 - number of busy registers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WID = ADDR_WID_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_v,
    input  logic [ADDR_WID-1:0]     set_addr,
    input  logic                    clr_v,
    input  logic [ADDR_WID-1:0]     clr_addr,
    output logic [2**ADDR_WID-1:0]  busy,
    output logic [ADDR_WID:0]       cnt
);

    localparam int unsigned CW = ADDR_WID + 1;

    logic                   set_hit;
    logic                   clr_hit;
    logic                   inc;
    logic                   dec;
    logic [2**ADDR_WID-1:0] busy_nxt;

    always_comb begin
        set_hit  = set_v && is_real_reg(32'(set_addr));
        // Issue wins over a same-address clear, so the clear is dropped.
        clr_hit  = clr_v && is_real_reg(32'(clr_addr)) &&
                   !(set_hit && (set_addr == clr_addr));
        busy_nxt = busy;
        if (clr_hit) busy_nxt[clr_addr] = 1'b0;
        if (set_hit) busy_nxt[set_addr] = 1'b1;
        // Count only real transitions so re-issues and writes to idle
        // registers leave cnt alone.
        inc = set_hit && !busy[set_addr];
        dec = clr_hit &&  busy[clr_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_nxt;
            case ({inc, dec})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard: two combinational read ports with
// optional write bypass, one write port, issue strobe and debug read port.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   rf_we/rf_addr/rf_din     - write port (writes to register 0 ignored)
//   rf_r1/rf_r2              - read addresses
//   rfd1/rfd2, rfb1/rfb2     - read data and busy flags
//   iss_v/iss_addr           - issue strobe marking a destination busy
//   busy_cnt                 - number of busy registers
//   dbg_addr/dbg_data        - debug read, registered contents only
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WID = DATA_WID_DEF,
    parameter int unsigned ADDR_WID = ADDR_WID_DEF,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rf_we,
    input  logic [ADDR_WID-1:0] rf_addr,
    input  logic [DATA_WID-1:0] rf_din,
    input  logic [ADDR_WID-1:0] rf_r1,
    input  logic [ADDR_WID-1:0] rf_r2,
    output logic [DATA_WID-1:0] rfd1,
    output logic [DATA_WID-1:0] rfd2,
    output logic                rfb1,
    output logic                rfb2,
    input  logic                iss_v,
    input  logic [ADDR_WID-1:0] iss_addr,
    output logic [ADDR_WID:0]   busy_cnt,
    input  logic [ADDR_WID-1:0] dbg_addr,
    output logic [DATA_WID-1:0] dbg_data
);

    localparam int unsigned DEPTH = 2**ADDR_WID;

    logic [DATA_WID-1:0] regs [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic                wr_hit;
    logic                byp1;
    logic                byp2;

    // rst_n gates the write so the bypass path also stays quiet in reset.
    assign wr_hit = rf_we && rst_n && is_real_reg(32'(rf_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[rf_addr] <= rf_din;
        end
    end

    regfile_scoreboard #(
        .ADDR_WID (ADDR_WID)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_v    (iss_v),
        .set_addr (iss_addr),
        .clr_v    (wr_hit),
        .clr_addr (rf_addr),
        .busy     (busy),
        .cnt      (busy_cnt)
    );

    always_comb begin
        byp1 = (BYPASS != 0) && wr_hit && (rf_r1 == rf_addr);
        byp2 = (BYPASS != 0) && wr_hit && (rf_r2 == rf_addr);

        rfd1 = byp1 ? rf_din : regs[rf_r1];
        rfd2 = byp2 ? rf_din : regs[rf_r2];

        // A bypassed write retires the register unless an issue to the
        // same address re-claims it this cycle; busy[0] is never set.
        rfb1 = busy[rf_r1] && !(byp1 && !(iss_v && (iss_addr == rf_r1)));
        rfb2 = busy[rf_r2] && !(byp2 && !(iss_v && (iss_addr == rf_r2)));

        dbg_data = regs[dbg_addr];
    end

endmodule
